// File: rtl/cpu_pkg.sv
// Shared types and mux-select encodings for the EX-stage forwarding logic.
package cpu_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [1:0] FWD_WB1 = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic             is_load;
  } stage_t;

  typedef struct packed {
    stage_t           st;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } ex_t;

endpackage

// File: rtl/fwd_sel_dec.sv
// Priority decode of one EX source operand against the MEM/WB/WB+1 writers.
module fwd_sel_dec
  import cpu_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b0
) (
  input  logic [REG_W-1:0] rs,
  input  stage_t           mem,
  input  stage_t           wb,
  input  stage_t           wb1,
  output logic [1:0]       sel
);

  function automatic logic hits(input stage_t s, input logic [REG_W-1:0] r);
    return s.valid && s.wr_en && (s.rd != '0) && (s.rd == r);
  endfunction

  // Nearest producer wins; WB+1 is only needed when the RF cannot write through.
  always_comb begin
    sel = FWD_RF;
    if (hits(mem, rs)) begin
      sel = FWD_MEM;
    end else if (hits(wb, rs)) begin
      sel = FWD_WB;
    end else if (!RF_BYPASS && hits(wb1, rs)) begin
      sel = FWD_WB1;
    end
  end

  logic unused_load_bits;
  assign unused_load_bits = ^{mem.is_load, wb.is_load, wb1.is_load};

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall controller for the 5-stage core; tracks
// destination metadata through EX/MEM/WB/WB+1 and counts stall cycles.
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int unsigned REG_W     = 3,
  parameter bit          RF_BYPASS = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  ex_t              ex_q, ex_d;
  stage_t           mem_q, wb_q, wb1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard;

  always_comb begin
    hazard = id_valid && ex_q.st.valid && ex_q.st.is_load && ex_q.st.wr_en &&
             (ex_q.st.rd != '0) && ((ex_q.st.rd == id_rs1) || (ex_q.st.rd == id_rs2));
    // A flushed dependent never reaches EX, so there is nothing to wait for.
    stall  = hazard && !flush;
  end

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.st.valid   = 1'b1;
      ex_d.st.rd      = id_rd;
      ex_d.st.wr_en   = id_wr_en;
      ex_d.st.is_load = id_is_load;
      ex_d.rs1        = id_rs1;
      ex_d.rs2        = id_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      wb1_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q.st;
      wb_q  <= mem_q;
      wb1_q <= wb_q;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stall_count = cnt_q;

  fwd_sel_dec #(
    .RF_BYPASS(RF_BYPASS)
  ) u_dec_a (
    .rs  (ex_q.rs1),
    .mem (mem_q),
    .wb  (wb_q),
    .wb1 (wb1_q),
    .sel (fwd_sel_a)
  );

  fwd_sel_dec #(
    .RF_BYPASS(RF_BYPASS)
  ) u_dec_b (
    .rs  (ex_q.rs2),
    .mem (mem_q),
    .wb  (wb_q),
    .wb1 (wb1_q),
    .sel (fwd_sel_b)
  );

`ifndef SYNTHESIS
  logic stall_prev_q;

  always_ff @(posedge clk) begin
    stall_prev_q <= rst ? 1'b0 : stall;
  end

  // Load data is not ready in MEM; the stall must keep dependents out of EX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(((fwd_sel_a == FWD_MEM) || (fwd_sel_b == FWD_MEM)) && mem_q.is_load));
      assert (!(stall_prev_q && stall));
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two DUT builds (WB+1 forwarding / write-through RF) against a pipeline model.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  typedef struct packed {
    logic        chk;
    logic [1:0]  a0, b0, a1, b1;
    logic        st;
    logic [3:0]  c0;
    logic [15:0] c1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_wr_en, id_is_load, flush;
  logic [2:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  sel_a0, sel_b0, sel_a1, sel_b1;
  logic        stall0, stall1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_W(3), .RF_BYPASS(1'b0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel_a(sel_a0), .fwd_sel_b(sel_b0), .stall(stall0), .stall_count(cnt0)
  );

  fwd_hazard_unit #(.REG_W(3), .RF_BYPASS(1'b1), .CNT_W(16)) dut_byp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel_a(sel_a1), .fwd_sel_b(sel_b1), .stall(stall1), .stall_count(cnt1)
  );

  // Model: p[0]=EX, p[1]=MEM, p[2]=WB, p[3]=WB+1, as whole instructions by age.
  ins_t        p[4];
  int          mc0, mc1;
  bit          known = 0;
  exp_t        q[$];
  int          total = 0, bad = 0;

  function automatic logic [1:0] model_sel(input logic [2:0] rs, input bit byp);
    for (int d = 1; d <= 3; d++) begin
      if (p[d].v && p[d].wr && p[d].rd != 0 && p[d].rd == rs) begin
        if (d == 3 && byp) return 2'd0;
        return 2'(d);
      end
    end
    return 2'd0;
  endfunction

  task automatic step(input ins_t i, input bit fl, input bit r, output bit st);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; flush = fl;
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_wr_en = i.wr; id_is_load = i.ld;
    st = i.v && p[0].v && p[0].ld && p[0].wr && p[0].rd != 0 &&
         (p[0].rd == i.rs1 || p[0].rd == i.rs2) && !fl;
    e.chk = known;
    e.a0 = model_sel(p[0].rs1, 0); e.b0 = model_sel(p[0].rs2, 0);
    e.a1 = model_sel(p[0].rs1, 1); e.b1 = model_sel(p[0].rs2, 1);
    e.st = st; e.c0 = 4'(mc0); e.c1 = 16'(mc1);
    q.push_back(e);
    if (r) begin
      for (int k = 0; k < 4; k++) p[k] = '0;
      mc0 = 0; mc1 = 0; known = 1;
    end else begin
      for (int k = 3; k > 0; k--) p[k] = p[k-1];
      p[0] = (i.v && !st && !fl) ? i : '0;
      if (st) begin
        if (mc0 < 15) mc0++;
        if (mc1 < 65535) mc1++;
      end
    end
  endtask

  task automatic issue(input ins_t i, input bit fl);
    bit s;
    step(i, fl, 0, s);
    for (int n = 0; n < 3 && s; n++) step(i, fl, 0, s);
  endtask

  function automatic ins_t mk(input bit v, input int rs1, input int rs2, input int rd,
                              input bit wr, input bit ld);
    ins_t i;
    i.v = v; i.rs1 = 3'(rs1); i.rs2 = 3'(rs2); i.rd = 3'(rd); i.wr = wr; i.ld = ld;
    return i;
  endfunction

  task automatic nops(input int n);
    bit s;
    for (int k = 0; k < n; k++) step('0, 0, 0, s);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          cmp("sel_a", 16'(sel_a0), 16'(e.a0));
          cmp("sel_b", 16'(sel_b0), 16'(e.b0));
          cmp("sel_a_byp", 16'(sel_a1), 16'(e.a1));
          cmp("sel_b_byp", 16'(sel_b1), 16'(e.b1));
          cmp("stall", 16'(stall0), 16'(e.st));
          cmp("stall_byp", 16'(stall1), 16'(e.st));
          cmp("count_sat4", 16'(cnt0), 16'(e.c0));
          cmp("count", cnt1, e.c1);
        end
      end
    end
  end

  initial begin : driver
    bit   s, hold;
    ins_t i, held;
    rst = 1; flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_wr_en = 0; id_is_load = 0;
    step('0, 0, 1, s);
    step('0, 0, 1, s);
    nops(2);
    // back-to-back, distance 2, distance 3
    issue(mk(1, 0, 0, 3, 1, 0), 0); issue(mk(1, 3, 0, 1, 1, 0), 0); nops(4);
    issue(mk(1, 0, 0, 4, 1, 0), 0); nops(1); issue(mk(1, 4, 4, 1, 1, 0), 0); nops(4);
    issue(mk(1, 0, 0, 6, 1, 0), 0); nops(2); issue(mk(1, 6, 0, 1, 1, 0), 0); nops(4);
    // load-use on operand B
    issue(mk(1, 0, 0, 5, 1, 1), 0); issue(mk(1, 1, 5, 2, 1, 0), 0); nops(4);
    // two writers of r2, nearest wins
    issue(mk(1, 0, 0, 2, 1, 0), 0); issue(mk(1, 0, 0, 2, 1, 0), 0);
    issue(mk(1, 2, 2, 1, 1, 0), 0); nops(4);
    // r0 and wr_en=0 producers never forward
    issue(mk(1, 0, 0, 0, 1, 0), 0); issue(mk(1, 0, 0, 7, 0, 1), 0);
    issue(mk(1, 7, 0, 0, 1, 1), 0); issue(mk(1, 0, 7, 1, 1, 0), 0); nops(4);
    // load-use coinciding with flush
    issue(mk(1, 0, 0, 1, 1, 1), 0); issue(mk(1, 1, 0, 2, 1, 0), 1); nops(4);
    // drive the narrow counter past saturation
    for (int k = 0; k < 20; k++) begin
      issue(mk(1, 0, 0, 3, 1, 1), 0); issue(mk(1, 3, 3, 4, 1, 0), 0);
    end
    nops(3);
    // reset with forwards pending
    issue(mk(1, 0, 0, 1, 1, 0), 0); issue(mk(1, 0, 0, 2, 1, 1), 0);
    step(mk(1, 2, 1, 3, 1, 0), 0, 1, s); nops(3);
    // randomized traffic; a stalled ID instruction is re-presented
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      i.v = ($urandom_range(7) != 0);
      i.rs1 = 3'($urandom_range(7)); i.rs2 = 3'($urandom_range(7));
      i.rd = 3'($urandom_range(7));
      i.wr = ($urandom_range(3) != 0); i.ld = ($urandom_range(2) == 0);
      if (hold) i = held;
      step(i, ($urandom_range(9) == 0), ($urandom_range(199) == 0), s);
      hold = s; held = i;
    end
    nops(3);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
